// File: rtl/lcd_timing_gen_param.sv
// Parametrised LCD timing generator: HSync/VSync/DE, frame RAM fetch,
// test patterns and frame-aligned start/stop, RGB565 parallel output.
// Ports: iClk/iRst (async, active high), iEn run request, iMode
// (0 RAM, 1 bars, 2 solid, 3 gray), iSolidColor, iRamRdData (1-cycle
// latency) / oRamRdAddr, oLcdHSync/oLcdVSync/oLcdDe/oLcdR/G/B,
// oFrameStart (pixel 0,0 on the outputs), oBusy (RUN or STOPPING).
module lcd_timing_gen_param #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int ADDR_W   = 17,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic [1:0]        iMode,
  input  logic [15:0]       iSolidColor,
  input  logic [15:0]       iRamRdData,
  output logic [ADDR_W-1:0] oRamRdAddr,
  output logic              oLcdHSync,
  output logic              oLcdVSync,
  output logic              oLcdDe,
  output logic [4:0]        oLcdR,
  output logic [5:0]        oLcdG,
  output logic [4:0]        oLcdB,
  output logic              oFrameStart,
  output logic              oBusy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW = $clog2(H_TOTAL);
  // at least 9 bits so the gray ramp can take h[8:4]
  localparam int HW = (HCW > 9) ? HCW : 9;
  localparam int VW = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
  localparam int BW = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int NPIX = H_ACTIVE * V_ACTIVE;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] BW_LAST = HW'(BW - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       solid_q, solid_d;
  logic [HW-1:0]     bcnt_q, bcnt_d;
  logic [2:0]        bidx_q, bidx_d;

  logic        de1_q, de1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        fs1_q, fs1_d;
  logic        ram1_q, ram1_d;
  logic [15:0] col1_q, col1_d;

  logic        de2_q, de2_d;
  logic        hs2_q, hs2_d;
  logic        vs2_q, vs2_d;
  logic        fs2_q, fs2_d;
  logic [15:0] rgb2_q, rgb2_d;

  logic        act;
  logic        h_last;
  logic        v_last;
  logic        frame_end;
  logic        vis;
  logic        new_frame;
  logic [4:0]  gray;
  logic [15:0] bar_col;
  logic [15:0] pat;

  always_comb begin
    act       = (state_q != S_IDLE);
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);
    frame_end = act && h_last && v_last;
    vis       = act && (h_q < H_ACT) && (v_q < V_ACT);
    new_frame = ((state_q == S_IDLE) && iEn) || frame_end;

    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (iEn) state_d = S_RUN;
      S_RUN:  if (!iEn) state_d = S_STOP;
      S_STOP: begin
        if (iEn) state_d = S_RUN;
        else if (frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    h_d = '0;
    v_d = '0;
    if (act) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end

    addr_d = '0;
    if (act) begin
      addr_d = addr_q;
      if (vis) addr_d = (addr_q == A_LAST) ? '0 : addr_q + 1'b1;
    end

    mode_d  = new_frame ? iMode : mode_q;
    solid_d = new_frame ? iSolidColor : solid_q;

    // bar position tracks h with a run counter; extra pixels stay on bar 7
    bcnt_d = '0;
    bidx_d = '0;
    if (act && !h_last) begin
      if (bcnt_q == BW_LAST) begin
        bcnt_d = '0;
        bidx_d = (bidx_q == 3'd7) ? bidx_q : bidx_q + 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
        bidx_d = bidx_q;
      end
    end

    unique case (bidx_q)
      3'd0: bar_col = 16'hFFFF;
      3'd1: bar_col = 16'hFFE0;
      3'd2: bar_col = 16'h07FF;
      3'd3: bar_col = 16'h07E0;
      3'd4: bar_col = 16'hF81F;
      3'd5: bar_col = 16'hF800;
      3'd6: bar_col = 16'h001F;
      default: bar_col = 16'h0000;
    endcase

    gray = h_q[8:4];
    unique case (mode_q)
      2'd1: pat = bar_col;
      2'd2: pat = solid_q;
      2'd3: pat = {gray, gray, gray[4], gray};
      default: pat = 16'h0000;
    endcase

    de1_d  = vis;
    hs1_d  = (act && h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs1_d  = (act && v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
    fs1_d  = act && (h_q == '0) && (v_q == '0);
    ram1_d = (mode_q == 2'd0);
    col1_d = vis ? pat : 16'h0000;

    // RAM data for the stage-1 address arrives this cycle
    de2_d  = de1_q;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    fs2_d  = fs1_q;
    rgb2_d = 16'h0000;
    if (de1_q) rgb2_d = ram1_q ? iRamRdData : col1_q;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      fs1_q   <= 1'b0;
      ram1_q  <= 1'b0;
      col1_q  <= '0;
      de2_q   <= 1'b0;
      hs2_q   <= ~HS_POL;
      vs2_q   <= ~VS_POL;
      fs2_q   <= 1'b0;
      rgb2_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      ram1_q  <= ram1_d;
      col1_q  <= col1_d;
      de2_q   <= de2_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      fs2_q   <= fs2_d;
      rgb2_q  <= rgb2_d;
    end
  end

  assign oRamRdAddr  = addr_q;
  assign oLcdHSync   = hs2_q;
  assign oLcdVSync   = vs2_q;
  assign oLcdDe      = de2_q;
  assign oLcdR       = rgb2_q[15:11];
  assign oLcdG       = rgb2_q[10:5];
  assign oLcdB       = rgb2_q[4:0];
  assign oFrameStart = fs2_q;
  assign oBusy       = (state_q != S_IDLE);

endmodule

// File: doc/lcd_timing_gen_param.md
# lcd_timing_gen_param

Parametrised LCD timing controller: successor to the fixed 480x272 RGB565 controller. Generates HSync/VSync/DE from configurable porch/sync parameters, fetches pixels from a synchronous frame RAM and drives an RGB565 parallel panel. Adds built-in test-pattern modes, programmable sync polarity and clean start/stop at frame boundaries. Sits between the frame buffer's read port and the panel pins, in the pixel-clock domain.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, HSync width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VSync width (lines)
- V_BP, 2, vertical back porch (lines)
- ADDR_W, 17, frame RAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- HS_POL, 0, HSync active level
- VS_POL, 0, VSync active level

- iClk  in  1  pixel clock; all logic on rising edge
- iRst  in  1  asynchronous, active-high reset
- iEn  in  1  run request; sampled every cycle
- iMode  in  2  0 frame RAM, 1 colour bars, 2 solid colour, 3 gray ramp
- iSolidColor  in  16  RGB565 value for mode 2
- iRamRdData  in  16  RAM read data, valid one cycle after oRamRdAddr
- oRamRdAddr  out  ADDR_W  RAM read address
- oLcdHSync  out  1  horizontal sync
- oLcdVSync  out  1  vertical sync
- oLcdDe  out  1  data enable, high on visible pixels
- oLcdR / oLcdG / oLcdB  out  5 / 6 / 5  pixel colour
- oFrameStart  out  1  one-cycle pulse aligned with pixel (0,0) on outputs
- oBusy  out  1  high in RUN and STOPPING

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, FP, sync, BP.
- Counters rH (0..H_TOTAL-1), rV (0..V_TOTAL-1); rV increments when rH wraps; both wrap to 0 at frame end.
- Active pixel: rH < H_ACTIVE and rV < V_ACTIVE. HSync active for rH in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VSync active for rV in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (whole lines). Active level per HS_POL/VS_POL.
- rAddr (= oRamRdAddr): index of next visible pixel; increments after each active pixel; wraps to 0 after H_ACTIVE*V_ACTIVE-1; holds during blanking. No multipliers.
- FSM: IDLE -> RUN on edge with iEn=1 (first RUN cycle has rH=rV=0). RUN -> STOPPING when iEn=0. STOPPING -> RUN if iEn returns to 1 before frame end. STOPPING -> IDLE at last cycle of frame (rH=H_TOTAL-1, rV=V_TOTAL-1). In IDLE counters and rAddr held at 0.
- Mode and iSolidColor latched only at frame start (entering RUN, or rH=rV=0 wrap); mid-frame changes take effect next frame.
- Colour bars: 8 bars, width H_ACTIVE/8 (integer; remainder pixels use last bar), order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000; bar index via run counter, no divider.
- Gray ramp: g = rH[8:4]; R=B=g, G={g,g[4]}.
- Blanking pixels: RGB = 0 in all modes.

## Timing
- Pipeline: cycle n counters/address; n+1 RAM data; all outputs registered at end of n+1, visible n+2. Syncs, DE, frame-start delayed equally (2 cycles), so all outputs stay mutually aligned in every mode.
- Reset / IDLE outputs: oRamRdAddr 0, oLcdDe 0, RGB 0, oFrameStart 0, oBusy 0, HSync = ~HS_POL, VSync = ~VS_POL. Pipeline flushes to these values 2 cycles after entering IDLE.
- iRst mid-frame: immediate return to reset values, FSM IDLE; no partial frame resumed.
- oBusy high from first RUN cycle through last STOPPING cycle (undelayed).

## Test plan
- Use H_ACTIVE=8,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1 (12x7, 84 clocks/frame) unless noted.
- Reset: assert iRst mid-frame -> all outputs at reset values same cycle, HSync=VSync=1; after release with iEn=0, oRamRdAddr stays 0, oLcdDe stays 0.
- Mode 0: RAM model returns data=addr; iEn=1 -> oRamRdAddr 0..7 in line 0, 8..15 line 1, ..., 31 then 0 next frame; oLcdDe high 8 cycles/line for 4 lines, RGB={addr}, oFrameStart pulse with first DE, HSync low 2 cycles at line positions 9-10, VSync low for line 5.
- Stop: drop iEn at rV=1 -> frame completes (32 DE pixels), oBusy falls after cycle 83, outputs idle 2 cycles later; re-raise iEn in STOPPING -> no gap, next frame starts at cycle 84.
- Colour bars (H_ACTIVE=16): each line outputs pairs FFFF,FFFF,FFE0,FFE0,...,0000,0000; mode switch to 2 mid-frame with iSolidColor=1234 -> current frame unchanged, next frame all DE pixels 1234.
- Defaults (480x272): frame length 525x286 = 150150 clocks; 130560 DE pixels; last address 0x1FDFF then wrap to 0.
